// File: rtl/trace_capture_unit.sv
// trace_capture_unit: timestamps fetch, data-access and retire events of each instruction
// and emits one trace record per retired instruction through a valid/ready register.
module trace_capture_unit #(
    parameter int INSTR_ADDR_WIDTH = 32,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int DATA_ADDR_WIDTH  = 32,
    parameter int TS_WIDTH         = 32,
    parameter int DEPTH            = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_req,
    input  logic                        instr_grant,
    input  logic                        instr_rvalid,
    input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    input  logic [INSTR_DATA_WIDTH-1:0] instr_rdata,
    input  logic                        data_mem_req,
    input  logic                        data_mem_grant,
    input  logic                        data_mem_rvalid,
    input  logic [DATA_ADDR_WIDTH-1:0]  data_mem_addr,
    input  logic                        retire_i,
    input  logic                        illegal_i,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [INSTR_ADDR_WIDTH-1:0] pc_o,
    output logic [INSTR_DATA_WIDTH-1:0] instr_o,
    output logic [DATA_ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [TS_WIDTH-1:0]         t_fetch_req_o,
    output logic [TS_WIDTH-1:0]         t_fetch_done_o,
    output logic [TS_WIDTH-1:0]         t_mem_req_o,
    output logic [TS_WIDTH-1:0]         t_mem_done_o,
    output logic [TS_WIDTH-1:0]         t_retire_o,
    output logic                        has_mem_o,
    output logic                        illegal_o,
    output logic [15:0]                 drop_count_o,
    output logic                        overflow_o,
    output logic                        sync_error_o
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_WIDTH-1:0]         ts;
    logic                        pend;
    logic [INSTR_ADDR_WIDTH-1:0] pend_pc;
    logic [TS_WIDTH-1:0]         pend_t;

    logic [INSTR_ADDR_WIDTH-1:0] q_pc    [DEPTH];
    logic [INSTR_DATA_WIDTH-1:0] q_instr [DEPTH];
    logic [DATA_ADDR_WIDTH-1:0]  q_maddr [DEPTH];
    logic [TS_WIDTH-1:0]         q_tfr   [DEPTH];
    logic [TS_WIDTH-1:0]         q_tfd   [DEPTH];
    logic [TS_WIDTH-1:0]         q_tmr   [DEPTH];
    logic [TS_WIDTH-1:0]         q_tmd   [DEPTH];
    logic [DEPTH-1:0]            q_mg, q_mw, q_hm;
    logic [AW-1:0]               head, tail;
    logic [AW:0]                 count;

    logic                        empty, full, push, pop, push_ok, dgrant, drv, load, sync_set, h_hm;
    logic [TS_WIDTH-1:0]         h_tmd;

    always_comb begin
        empty    = count == '0;
        full     = count == (AW+1)'(DEPTH);
        push     = instr_rvalid && pend;
        pop      = retire_i && !empty;
        push_ok  = push && (!full || pop);
        // q_mg marks that the head already saw its first data grant; q_mw that it awaits rvalid
        dgrant   = data_mem_req && data_mem_grant && !empty && !q_mg[head];
        drv      = data_mem_rvalid && !empty && q_mw[head];
        h_hm     = q_hm[head] || drv;
        h_tmd    = drv ? ts : q_tmd[head];
        load     = pop && (!trace_valid_o || trace_ready_i);
        sync_set = (instr_rvalid && !pend) || (data_mem_req && data_mem_grant && empty) ||
                   (retire_i && empty) || (push && !push_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts             <= '0;
            pend           <= 1'b0;
            pend_pc        <= '0;
            pend_t         <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            trace_valid_o  <= 1'b0;
            pc_o           <= '0;
            instr_o        <= '0;
            mem_addr_o     <= '0;
            t_fetch_req_o  <= '0;
            t_fetch_done_o <= '0;
            t_mem_req_o    <= '0;
            t_mem_done_o   <= '0;
            t_retire_o     <= '0;
            has_mem_o      <= 1'b0;
            illegal_o      <= 1'b0;
            drop_count_o   <= '0;
            overflow_o     <= 1'b0;
            sync_error_o   <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            // a completing fetch clears pending before a same-cycle grant re-arms it
            if (push) pend <= 1'b0;
            if (instr_req && instr_grant) begin
                pend    <= 1'b1;
                pend_pc <= instr_addr;
                pend_t  <= ts;
            end
            head  <= head + AW'(pop);
            tail  <= tail + AW'(push_ok);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            trace_valid_o <= load || (trace_valid_o && !trace_ready_i);
            if (load) begin
                pc_o           <= q_pc[head];
                instr_o        <= q_instr[head];
                t_fetch_req_o  <= q_tfr[head];
                t_fetch_done_o <= q_tfd[head];
                mem_addr_o     <= h_hm ? q_maddr[head] : '0;
                t_mem_req_o    <= h_hm ? q_tmr[head] : '0;
                t_mem_done_o   <= h_hm ? h_tmd : '0;
                has_mem_o      <= h_hm;
                t_retire_o     <= ts;
                illegal_o      <= illegal_i;
            end
            if (pop && !load && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
            overflow_o   <= overflow_o || (pop && !load);
            sync_error_o <= sync_error_o || sync_set;
        end
    end

    always_ff @(posedge clk) begin
        if (dgrant) begin
            q_mg[head]    <= 1'b1;
            q_mw[head]    <= 1'b1;
            q_maddr[head] <= data_mem_addr;
            q_tmr[head]   <= ts;
        end
        if (drv) begin
            q_mw[head]  <= 1'b0;
            q_hm[head]  <= 1'b1;
            q_tmd[head] <= ts;
        end
        // a push into a slot being popped in the same cycle must win over head updates
        if (push_ok) begin
            q_pc[tail]    <= pend_pc;
            q_instr[tail] <= instr_rdata;
            q_tfr[tail]   <= pend_t;
            q_tfd[tail]   <= ts;
            q_mg[tail]    <= 1'b0;
            q_mw[tail]    <= 1'b0;
            q_hm[tail]    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_trace_capture_unit.sv
// tb_trace_capture_unit: directed scenarios plus random traffic against a queue-based model;
// a negedge monitor pops expected records whenever a record is handed off.
module tb_trace_capture_unit;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req = 0, instr_grant = 0, instr_rvalid = 0;
    logic [31:0] instr_addr = 0, instr_rdata = 0, data_mem_addr = 0;
    logic        data_mem_req = 0, data_mem_grant = 0, data_mem_rvalid = 0;
    logic        retire_i = 0, illegal_i = 0, trace_ready_i = 1;

    logic        trace_valid_o, has_mem_o, illegal_o, overflow_o, sync_error_o;
    logic [31:0] pc_o, instr_o, mem_addr_o, t_fetch_req_o, t_fetch_done_o, t_mem_req_o, t_mem_done_o, t_retire_o;
    logic [15:0] drop_count_o;

    logic        w_valid, w_has_mem, w_illegal, w_overflow, w_sync;
    logic [31:0] w_pc, w_instr, w_mem_addr;
    logic [3:0]  w_tfr, w_tfd, w_tmr, w_tmd, w_tret;
    logic [15:0] w_drop;

    always #5 clk = ~clk;

    trace_capture_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instr_req(instr_req), .instr_grant(instr_grant), .instr_rvalid(instr_rvalid),
        .instr_addr(instr_addr), .instr_rdata(instr_rdata), .data_mem_req(data_mem_req),
        .data_mem_grant(data_mem_grant), .data_mem_rvalid(data_mem_rvalid), .data_mem_addr(data_mem_addr),
        .retire_i(retire_i), .illegal_i(illegal_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .pc_o(pc_o), .instr_o(instr_o), .mem_addr_o(mem_addr_o), .t_fetch_req_o(t_fetch_req_o),
        .t_fetch_done_o(t_fetch_done_o), .t_mem_req_o(t_mem_req_o), .t_mem_done_o(t_mem_done_o),
        .t_retire_o(t_retire_o), .has_mem_o(has_mem_o), .illegal_o(illegal_o), .drop_count_o(drop_count_o),
        .overflow_o(overflow_o), .sync_error_o(sync_error_o));

    trace_capture_unit #(.DEPTH(DEPTH), .TS_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .instr_req(instr_req), .instr_grant(instr_grant), .instr_rvalid(instr_rvalid),
        .instr_addr(instr_addr), .instr_rdata(instr_rdata), .data_mem_req(data_mem_req),
        .data_mem_grant(data_mem_grant), .data_mem_rvalid(data_mem_rvalid), .data_mem_addr(data_mem_addr),
        .retire_i(retire_i), .illegal_i(illegal_i), .trace_valid_o(w_valid), .trace_ready_i(trace_ready_i),
        .pc_o(w_pc), .instr_o(w_instr), .mem_addr_o(w_mem_addr), .t_fetch_req_o(w_tfr),
        .t_fetch_done_o(w_tfd), .t_mem_req_o(w_tmr), .t_mem_done_o(w_tmd),
        .t_retire_o(w_tret), .has_mem_o(w_has_mem), .illegal_o(w_illegal), .drop_count_o(w_drop),
        .overflow_o(w_overflow), .sync_error_o(w_sync));

    typedef struct {
        logic [31:0] pc, instr, tfr, tfd, maddr, tmr, tmd;
        bit granted, waiting, hm;
    } ent_t;
    typedef struct {
        logic [31:0] pc, instr, tfr, tfd, maddr, tmr, tmd, tret;
        bit hm, ill;
    } rec_t;

    ent_t        mq[$];
    rec_t        exp_q[$];
    logic [31:0] m_ts, m_pend_pc, m_pend_t;
    bit          m_pend, m_valid, m_sync, m_ovf;
    bit          c_valid, c_sync, c_ovf;
    int          m_drop, c_drop;
    int          total = 0, passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ts = 0; m_pend = 0; m_valid = 0; m_sync = 0; m_ovf = 0; m_drop = 0;
        c_valid = 0; c_sync = 0; c_ovf = 0; c_drop = 0;
    endtask

    // effect of the coming clock edge given the inputs currently driven
    task automatic model_step();
        bit was_empty;
        ent_t h;
        rec_t r;
        was_empty = mq.size() == 0;
        if (data_mem_rvalid && !was_empty && mq[0].waiting) begin
            mq[0].waiting = 0; mq[0].hm = 1; mq[0].tmd = m_ts;
        end
        if (data_mem_req && data_mem_grant) begin
            if (was_empty) m_sync = 1;
            else if (!mq[0].granted) begin
                mq[0].granted = 1; mq[0].waiting = 1; mq[0].maddr = data_mem_addr; mq[0].tmr = m_ts;
            end
        end
        if (retire_i && was_empty) m_sync = 1;
        if (retire_i && !was_empty) begin
            h = mq.pop_front();
            r.pc = h.pc; r.instr = h.instr; r.tfr = h.tfr; r.tfd = h.tfd;
            r.hm = h.hm;
            r.maddr = h.hm ? h.maddr : 0;
            r.tmr = h.hm ? h.tmr : 0;
            r.tmd = h.hm ? h.tmd : 0;
            r.tret = m_ts; r.ill = illegal_i;
            if (!m_valid || trace_ready_i) begin
                m_valid = 1;
                exp_q.push_back(r);
            end else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        end else if (m_valid && trace_ready_i) m_valid = 0;
        if (instr_rvalid) begin
            if (!m_pend) m_sync = 1;
            else begin
                m_pend = 0;
                if (mq.size() < DEPTH) begin
                    h = '{pc: m_pend_pc, instr: instr_rdata, tfr: m_pend_t, tfd: m_ts,
                          maddr: 0, tmr: 0, tmd: 0, granted: 0, waiting: 0, hm: 0};
                    mq.push_back(h);
                end else m_sync = 1;
            end
        end
        if (instr_req && instr_grant) begin
            m_pend = 1; m_pend_pc = instr_addr; m_pend_t = m_ts;
        end
        m_ts++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        c_valid = m_valid; c_sync = m_sync; c_ovf = m_ovf; c_drop = m_drop;
    endtask

    task automatic clr();
        instr_req = 0; instr_grant = 0; instr_rvalid = 0;
        data_mem_req = 0; data_mem_grant = 0; data_mem_rvalid = 0;
        retire_i = 0; illegal_i = 0;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic fetch_grant(input logic [31:0] a);
        instr_req = 1; instr_grant = 1; instr_addr = a;
    endtask

    rec_t e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", trace_valid_o, c_valid);
            chk("valid_w", w_valid, c_valid);
            chk("sync_error", sync_error_o, c_sync);
            chk("overflow", overflow_o, c_ovf);
            chk("drop_count", drop_count_o, c_drop);
            if (trace_valid_o) begin
                if (exp_q.size() == 0) chk("unexpected_record", 1, 0);
                else begin
                    e = exp_q[0];
                    chk("pc", pc_o, e.pc);
                    chk("instr", instr_o, e.instr);
                    chk("t_fetch_req", t_fetch_req_o, e.tfr);
                    chk("t_fetch_done", t_fetch_done_o, e.tfd);
                    chk("mem_addr", mem_addr_o, e.maddr);
                    chk("t_mem_req", t_mem_req_o, e.tmr);
                    chk("t_mem_done", t_mem_done_o, e.tmd);
                    chk("t_retire", t_retire_o, e.tret);
                    chk("has_mem", has_mem_o, e.hm);
                    chk("illegal", illegal_o, e.ill);
                    chk("t_fetch_req_w", w_tfr, e.tfr[3:0]);
                    chk("t_fetch_done_w", w_tfd, e.tfd[3:0]);
                    chk("t_mem_done_w", w_tmd, e.tmd[3:0]);
                    chk("t_retire_w", w_tret, e.tret[3:0]);
                    if (trace_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", trace_valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_drop", drop_count_o, 0);
        chk("rst_sync", sync_error_o, 0);
        rst = 0;

        // first record: fetch at 3, data at 5, retire at 9
        idle(3);
        fetch_grant(32'h100); tick(); clr();
        idle(1);
        instr_rvalid = 1; instr_rdata = 32'h13; tick(); clr();
        idle(3);
        retire_i = 1; tick(); clr();
        chk("r36_valid", trace_valid_o, 1);
        chk("r36_pc", pc_o, 32'h100);
        chk("r36_instr", instr_o, 32'h13);
        chk("r36_tfr", t_fetch_req_o, 3);
        chk("r36_tfd", t_fetch_done_o, 5);
        chk("r36_tret", t_retire_o, 9);
        chk("r36_has_mem", has_mem_o, 0);
        idle(2);

        // record with a data access
        do_reset();
        idle(1);
        fetch_grant(32'h200); tick(); clr();
        idle(1);
        instr_rvalid = 1; instr_rdata = 32'h2283; tick(); clr();
        idle(3);
        data_mem_req = 1; data_mem_grant = 1; data_mem_addr = 32'h2000; tick(); clr();
        data_mem_rvalid = 1; tick(); clr();
        idle(1);
        retire_i = 1; tick(); clr();
        chk("r37_has_mem", has_mem_o, 1);
        chk("r37_mem_addr", mem_addr_o, 32'h2000);
        chk("r37_tmr", t_mem_req_o, 7);
        chk("r37_tmd", t_mem_done_o, 8);
        chk("r37_tret", t_retire_o, 10);
        idle(2);

        // back-pressure: three retires while the register is held
        do_reset();
        trace_ready_i = 0;
        fetch_grant(32'hA0); tick(); clr();
        fetch_grant(32'hA4); instr_rvalid = 1; instr_rdata = 1; tick(); clr();
        fetch_grant(32'hA8); instr_rvalid = 1; instr_rdata = 2; tick(); clr();
        instr_rvalid = 1; instr_rdata = 3; tick(); clr();
        for (int i = 0; i < 3; i++) begin
            retire_i = 1; tick(); clr();
        end
        chk("r38_pc_held", pc_o, 32'hA0);
        chk("r38_drop", drop_count_o, 2);
        chk("r38_overflow", overflow_o, 1);
        chk("r38_sync", sync_error_o, 0);
        trace_ready_i = 1;
        idle(2);

        // retire on an empty queue
        do_reset();
        idle(1);
        retire_i = 1; tick(); clr();
        chk("r41_valid", trace_valid_o, 0);
        chk("r41_sync", sync_error_o, 1);

        // reset while a fetch is pending and a record is held
        do_reset();
        fetch_grant(32'h300); tick(); clr();
        fetch_grant(32'h304); instr_rvalid = 1; instr_rdata = 32'h33; tick(); clr();
        trace_ready_i = 0;
        retire_i = 1; tick(); clr();
        chk("mid_valid_before", trace_valid_o, 1);
        rst = 1;
        model_reset();
        #1;
        chk("mid_valid", trace_valid_o, 0);
        chk("mid_pc", pc_o, 0);
        chk("mid_instr", instr_o, 0);
        chk("mid_tret", t_retire_o, 0);
        chk("mid_tret_w", w_tret, 0);
        @(posedge clk);
        #1;
        rst = 0;
        trace_ready_i = 1;
        instr_rvalid = 1; tick(); clr();
        chk("mid_stale_rvalid_sync", sync_error_o, 1);

        // DEPTH+1 completions with no retire, then drain in order
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            fetch_grant(32'h400 + 32'(4 * i));
            instr_rvalid = i > 0; instr_rdata = 32'h1000 + 32'(i);
            tick(); clr();
        end
        instr_rvalid = 1; instr_rdata = 32'h1FFF; tick(); clr();
        chk("r39_sync", sync_error_o, 1);
        chk("r39_no_valid", trace_valid_o, 0);
        for (int i = 0; i < DEPTH; i++) begin
            retire_i = 1; tick(); clr();
        end
        chk("r39_last_pc", pc_o, 32'h400 + 32'(4 * (DEPTH - 1)));
        idle(2);
        chk("r39_drained", exp_q.size(), 0);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            clr();
            instr_req     = $urandom_range(0, 2) == 0;
            instr_grant   = instr_req && $urandom_range(0, 1);
            instr_addr    = $urandom;
            instr_rvalid  = m_pend ? $urandom_range(0, 4) != 0 : $urandom_range(0, 30) == 0;
            instr_rdata   = $urandom;
            data_mem_req  = $urandom_range(0, 2) == 0;
            data_mem_grant = data_mem_req && $urandom_range(0, 1);
            data_mem_addr = $urandom;
            data_mem_rvalid = $urandom_range(0, 2) == 0;
            retire_i      = mq.size() != 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 40) == 0;
            illegal_i     = $urandom_range(0, 3) == 0;
            trace_ready_i = $urandom_range(0, 3) != 0;
            tick();
        end
        clr();
        trace_ready_i = 1;
        idle(3);
        chk("rand_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/trace_capture_unit.md
TRACE_CAPTURE_UNIT -- requirements
Module: trace_capture_unit

Interface
REQ-001 SHALL have parameter INSTR_ADDR_WIDTH, default 32: instruction address width.
REQ-002 SHALL have parameter INSTR_DATA_WIDTH, default 32: instruction word width.
REQ-003 SHALL have parameter DATA_ADDR_WIDTH, default 32: data address width.
REQ-004 SHALL have parameter TS_WIDTH, default 32: timestamp width.
REQ-005 SHALL have parameter DEPTH, default 8 (power of two, >=2): in-flight queue entries.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have ports instr_req, instr_grant, instr_rvalid, input, 1: fetch handshake.
REQ-009 SHALL have ports instr_addr (INSTR_ADDR_WIDTH) and instr_rdata (INSTR_DATA_WIDTH), input: fetch address and data.
REQ-010 SHALL have ports data_mem_req, data_mem_grant, data_mem_rvalid, input, 1: data handshake.
REQ-011 SHALL have port data_mem_addr, input, DATA_ADDR_WIDTH: data address.
REQ-012 SHALL have ports retire_i and illegal_i, input, 1: instruction leaves WB; illegal flag qualifying retire_i.
REQ-013 SHALL have ports trace_valid_o, output, 1, and trace_ready_i, input, 1: record handshake.
REQ-014 SHALL have record outputs: pc_o, instr_o, mem_addr_o, t_fetch_req_o, t_fetch_done_o, t_mem_req_o, t_mem_done_o, t_retire_o (TS_WIDTH each), has_mem_o, illegal_o.
REQ-015 SHALL have outputs drop_count_o (16 bits), overflow_o (1 bit) and sync_error_o (1 bit).

Function
REQ-016 SHALL keep a timestamp that is 0 during reset, increments by 1 every clock and wraps modulo 2^TS_WIDTH.
REQ-017 SHALL, on instr_req&&instr_grant, latch instr_addr and the current timestamp into a single pending-fetch register and set it pending.
REQ-018 SHALL, on instr_rvalid with a fetch pending, push {pc, instr_rdata, t_fetch_req, t_fetch_done = current timestamp} into the in-flight queue.
REQ-019 SHALL handle instr_rvalid and a new grant in the same cycle by completing the old fetch and then starting the new one.
REQ-020 SHALL ignore instr_rvalid with no fetch pending and set sync_error_o.
REQ-021 SHALL, on data_mem_req&&data_mem_grant with the queue non-empty, record data_mem_addr and t_mem_req on the head (oldest) entry.
REQ-022 SHALL record the first data access of an entry only; a later grant on that entry SHALL be ignored.
REQ-023 SHALL, on the next data_mem_rvalid after a recorded grant, record t_mem_done on the head entry and set has_mem.
REQ-024 SHALL ignore a data grant on an empty queue and set sync_error_o.
REQ-025 SHALL, on retire_i, pop the head and stamp t_retire with the current timestamp and illegal with illegal_i.
REQ-026 SHALL clear the mem fields and has_mem of an entry that retires with no data access.
REQ-027 SHALL ignore retire_i on an empty queue (including a push in the same cycle) and set sync_error_o.
REQ-028 SHALL accept a push when the queue is full only if a pop happens in the same cycle; otherwise it SHALL drop the fetch and set sync_error_o.
REQ-029 SHALL hold the popped record in a single output register; retire in cycle N SHALL give trace_valid_o=1 in cycle N+1.
REQ-030 SHALL transfer a record on trace_valid_o&&trace_ready_i, and a new record MAY load into the register in the same cycle.
REQ-031 SHALL keep the record outputs stable while trace_valid_o=1 and trace_ready_i=0.
REQ-032 SHALL, on a retire while the output register is held, discard the new record, increment drop_count_o (saturating at 0xFFFF) and set overflow_o.
REQ-033 SHALL make sync_error_o and overflow_o sticky until reset.

Reset
REQ-034 SHALL, while rst=1, clear the timestamp, queue, pending fetch, trace_valid_o, all record outputs, drop_count_o, overflow_o and sync_error_o to 0, asynchronously.
REQ-035 SHALL discard in-flight fetches and queued entries on reset mid-operation; an instr_rvalid after reset SHALL set sync_error_o.

Verification
REQ-036 SHALL cover: release reset; grant addr 0x100 at ts 3; rvalid data 0x13 at ts 5; retire at ts 9 -> next cycle valid, pc 0x100, instr 0x13, t 3/5/9, has_mem 0.
REQ-037 SHALL cover: fetch, then data grant addr 0x2000 at ts 7, rvalid at ts 8, retire at ts 10 -> has_mem 1, mem_addr 0x2000, t_mem 7/8.
REQ-038 SHALL cover: trace_ready_i=0 and 3 retires -> first record held unchanged, drop_count_o=2, overflow_o=1.
REQ-039 SHALL cover: DEPTH+1 fetch completions with no retire -> DEPTH entries queued, sync_error_o=1; then DEPTH retires -> DEPTH records in order.
REQ-040 SHALL cover: TS_WIDTH=4 for 20 cycles -> timestamp wraps 15->0; rst asserted mid-fetch -> all outputs 0 immediately.
REQ-041 SHALL cover: retire_i on an empty queue -> no trace_valid_o, sync_error_o=1.
